dmem_bus_arbiter: RTL and testbench
===================================

// Module: dmem_bus_arbiter
// PURPOSE
//  Shares the single-port data memory / memory-mapped I/O bus (dmem, HEX, LEDR, LEDG, KEY, SW)
//  between two requesters: port 0 = CPU memory stage, port 1 = secondary master (loader/debug/DMA).
//  Fixed priority to port 0 with a starvation guard for port 1, plus a bus lock for atomic
//  read-modify-write sequences. Sits between the masters and the dmem/IO address decode.
// PARAMETERS
//  DBITS         32  data and address width
//  STARVE_LIMIT  4   consecutive lost cycles for port 1 before port 1 is forced to win
//  LOCKMAX       8   max consecutive locked cycles before the watchdog breaks the lock
// PORTS
//  clk          in   1      system clock; all state updates on posedge clk
//  reset        in   1      synchronous, active-high
//  reqN         in   1      N=0,1: access request, held until gntN
//  weN          in   1      1=write, 0=read
//  lockN        in   1      keep ownership after this access
//  addrN        in   DBITS  byte address
//  wdataN       in   DBITS  write data
//  gntN         out  1      combinational grant; access is issued this cycle
//  rvalidN      out  1      read data valid, one cycle after read grant
//  rdataN       out  DBITS  read data (mem_rdata passthrough, qualified by rvalidN)
//  mem_en       out  1      bus access this cycle
//  mem_we       out  1      write strobe
//  mem_addr     out  DBITS  muxed address
//  mem_wdata    out  DBITS  muxed write data
//  mem_rdata    in   DBITS  synchronous read data, valid cycle after mem_en&!mem_we
//  err_lock     out  1      one-cycle pulse when the watchdog breaks a lock
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. During and after reset: state=IDLE,
//    starve_cnt=0, lock_cnt=0, rvalid0/1=0, err_lock=0. gnt0/1, mem_en, mem_we are forced to 0
//    while reset=1. mem_addr and mem_wdata are 0 when mem_en=0.
//  - FSM states: IDLE, OWN0, OWN1.
//    IDLE: req0 only -> gnt0. req1 only -> gnt1. Both -> gnt0, unless starve_cnt==STARVE_LIMIT,
//      then gnt1.
//      Granted port with lock=1 -> OWNn next cycle; otherwise stay IDLE.
//    OWNn: only port n may be granted; the other port's gnt=0 regardless of starve_cnt.
//      Exit to IDLE in any cycle where lockN=0, whether or not reqN is asserted.
//  - At most one gnt per cycle. In the grant cycle: mem_en=1, mem_we=weN, mem_addr=addrN,
//    mem_wdata=wdataN.
//  - Reads: rvalidN=1 exactly one cycle after the read grant; rdataN=mem_rdata.
//    Writes never raise rvalid. Back-to-back grants yield back-to-back rvalids, each steered to
//    the correct port by a 1-bit response-tag register.
//  - starve_cnt: increments (saturating at STARVE_LIMIT) each cycle req1=1 and gnt1=0.
//    Clears on gnt1, or on a cycle with req1=0.
//  - lock_cnt: counts cycles spent in OWNn; clears on any entry to IDLE.
//    When lock_cnt reaches LOCKMAX-1 while still locked:
//      next state = IDLE; err_lock pulses for 1 cycle; the lock owner's lock is then ignored
//      until its lock input drops to 0.
//  - Reset mid-operation: an outstanding read response is dropped (no rvalid after reset).
//  - The arbiter performs no address decode; ranges such as 0xF0000000..0xF0000014 pass through.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE/OWN0/OWN1), port index constants,
//    and default STARVE_LIMIT/LOCKMAX.
//  - One sub-module: arb_sat_counter (parameterised saturating counter with clear),
//    instantiated for starve_cnt and lock_cnt. Grant mux and FSM stay in this file.
// TESTING
//  1. req0 read addr=0x40, mem_rdata=0x1234 -> gnt0 and mem_en same cycle, mem_addr=0x40;
//     next cycle rvalid0=1, rdata0=0x1234, rvalid1=0.
//  2. req0 and req1 held high for 6 cycles, STARVE_LIMIT=4 -> gnt0 in cycles 1-4, gnt1 in
//     cycle 5, gnt0 in cycle 6; starve_cnt=0 after cycle 5.
//  3. Port 1 locked read of 0x100 then unlocked write 0x5 to 0x100 while req0 held ->
//     gnt0=0 for both cycles, mem_wdata=0x5 in the second cycle, gnt0 in the third.
//  4. LOCKMAX=8; port 0 locks, then holds lock0=1 with req0=0 while req1=1 ->
//     err_lock pulses after 8 locked cycles, then gnt1; port 0 cannot re-lock until lock0 drops.
//  5. Read granted to port 1, reset asserted the next cycle -> rvalid1=0, all gnt/mem_en=0,
//     state=IDLE; first request after reset is served normally.
//  6. Alternating read(port0)/read(port1) every cycle -> rvalid alternates 0/1 with matching
//     data and no lost or misrouted responses.

Source files
------------

// File: rtl/dmem_bus_arbiter_pkg.sv
// Shared definitions for the data-memory bus arbiter: FSM encoding, port indices,
// default limits and a counter-width helper.
package dmem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  localparam int PORT0            = 0;
  localparam int PORT1            = 1;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_LOCKMAX      = 8;

  // Bits needed to hold 0..max; never narrower than one bit.
  function automatic int cnt_width(input int max);
    return (max < 2) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Up-counter that holds at MAX; clear and reset both win over increment.
module arb_sat_counter
  import dmem_bus_arbiter_pkg::*;
#(
  parameter int MAX = 4,
  parameter int W   = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != W'(MAX))) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Two-master arbiter for the dmem / memory-mapped I/O bus: port 0 has priority,
// port 1 has a starvation guard, and either port may lock the bus with a watchdog.
module dmem_bus_arbiter
  import dmem_bus_arbiter_pkg::*;
#(
  parameter  int DBITS        = 32,
  parameter  int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter  int LOCKMAX      = DEF_LOCKMAX,
  localparam int SCW          = cnt_width(STARVE_LIMIT),
  localparam int LCW          = cnt_width(LOCKMAX - 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             we0,
  input  logic             lock0,
  input  logic [DBITS-1:0] addr0,
  input  logic [DBITS-1:0] wdata0,
  output logic             gnt0,
  output logic             rvalid0,
  output logic [DBITS-1:0] rdata0,
  input  logic             req1,
  input  logic             we1,
  input  logic             lock1,
  input  logic [DBITS-1:0] addr1,
  input  logic [DBITS-1:0] wdata1,
  output logic             gnt1,
  output logic             rvalid1,
  output logic [DBITS-1:0] rdata1,
  output logic             mem_en,
  output logic             mem_we,
  output logic [DBITS-1:0] mem_addr,
  output logic [DBITS-1:0] mem_wdata,
  input  logic [DBITS-1:0] mem_rdata,
  output logic             err_lock,
  output arb_state_t       arb_state,
  output logic [SCW-1:0]   starve_cnt,
  output logic [LCW-1:0]   lock_cnt
);

  // Handshake: a master raises reqN and holds it with stable we/addr/wdata until
  // gntN is seen high in the same cycle; that cycle is the bus access. A read
  // answers with rvalidN exactly one cycle later, with no back-pressure.

  arb_state_t state_q, state_d;
  logic       watchdog;
  logic       lock_eff0, lock_eff1;
  logic [1:0] lock_ign_q;
  logic       rv_q, rtag_q, err_q;

  assign lock_eff0 = lock0 & ~lock_ign_q[0];
  assign lock_eff1 = lock1 & ~lock_ign_q[1];

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    watchdog = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt0 && lock_eff0)      state_d = ST_OWN0;
        else if (gnt1 && lock_eff1) state_d = ST_OWN1;
      end
      ST_OWN0: begin
        if (!lock0) begin
          state_d = ST_IDLE;
        end else if (lock_cnt == LCW'(LOCKMAX - 1)) begin
          state_d  = ST_IDLE;
          watchdog = 1'b1;
        end
      end
      ST_OWN1: begin
        if (!lock1) begin
          state_d = ST_IDLE;
        end else if (lock_cnt == LCW'(LOCKMAX - 1)) begin
          state_d  = ST_IDLE;
          watchdog = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_IDLE: begin
          if (req0 && req1) begin
            if (starve_cnt == SCW'(STARVE_LIMIT)) gnt1 = 1'b1;
            else                                  gnt0 = 1'b1;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
        ST_OWN0: gnt0 = req0;
        ST_OWN1: gnt1 = req1;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_en    = gnt0 | gnt1;
    mem_we    = (gnt0 & we0) | (gnt1 & we1);
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end else if (gnt0) begin
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end
  end

  // rtag_q remembers which port owns the read data arriving next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rv_q       <= 1'b0;
      rtag_q     <= 1'b0;
      err_q      <= 1'b0;
      lock_ign_q <= 2'b00;
    end else begin
      rv_q          <= mem_en & ~mem_we;
      rtag_q        <= gnt1;
      err_q         <= watchdog;
      lock_ign_q[0] <= (lock_ign_q[0] | (watchdog & (state_q == ST_OWN0))) & lock0;
      lock_ign_q[1] <= (lock_ign_q[1] | (watchdog & (state_q == ST_OWN1))) & lock1;
    end
  end

  // Gating with reset drops a response that was in flight when reset arrived.
  assign rvalid0   = rv_q & ~rtag_q & ~reset;
  assign rvalid1   = rv_q &  rtag_q & ~reset;
  assign rdata0    = mem_rdata;
  assign rdata1    = mem_rdata;
  assign err_lock  = err_q & ~reset;
  assign arb_state = state_q;

  arb_sat_counter #(.MAX(STARVE_LIMIT), .W(SCW)) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (gnt1 | ~req1),
    .inc   (req1 & ~gnt1),
    .count (starve_cnt)
  );

  arb_sat_counter #(.MAX(LOCKMAX - 1), .W(LCW)) u_lock_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state_d == ST_IDLE),
    .inc   (state_q != ST_IDLE),
    .count (lock_cnt)
  );

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Randomized bench for dmem_bus_arbiter: a per-cycle reference model predicts
// grants and bus muxing; read responses go through an expected queue.
module tb_dmem_bus_arbiter;
  import dmem_bus_arbiter_pkg::*;

  localparam int DBITS = 32;
  localparam int SL    = 4;
  localparam int LM    = 8;
  localparam int EW    = 16 + 1 + DBITS;
  localparam int NCYC  = 3000;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0, req1, we0, we1, lock0, lock1;
  logic [DBITS-1:0] addr0, addr1, wdata0, wdata1;
  logic             gnt0, gnt1, rvalid0, rvalid1;
  logic [DBITS-1:0] rdata0, rdata1;
  logic             mem_en, mem_we;
  logic [DBITS-1:0] mem_addr, mem_wdata, mem_rdata;
  logic             err_lock;
  arb_state_t       arb_state;
  logic [2:0]       starve_cnt, lock_cnt;

  always #5 clk = ~clk;

  dmem_bus_arbiter #(.DBITS(DBITS), .STARVE_LIMIT(SL), .LOCKMAX(LM)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err_lock(err_lock),
    .arb_state(arb_state), .starve_cnt(starve_cnt), .lock_cnt(lock_cnt)
  );

  int total = 0;
  int bad   = 0;
  logic [15:0] cyc = '0;
  logic [EW-1:0] exp_q[$];

  // Stimulus held per port, plus model state expressed as owner / counts.
  logic             rq[2], wr[2], lk[2], gnt_prev[2];
  logic [DBITS-1:0] ad[2], wd[2];
  logic [DBITS-1:0] bmem[16], mmem[16];
  logic             resp_pend;
  logic [DBITS-1:0] resp;
  int  owner, starve, lockc;
  bit  ign[2];
  bit  err_pend;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Response monitor: pops on every rvalid and flags anything overdue.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rvalid0 && rvalid1) chk("rvalid_both", 1, 0);
    if (rvalid0 || rvalid1) begin
      if (exp_q.size() == 0) begin
        chk("rvalid_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rv_port", 64'(rvalid1), 64'(e[DBITS]));
        chk("rv_data", 64'(rvalid1 ? rdata1 : rdata0), 64'(e[DBITS-1:0]));
        chk("rv_cycle", 64'(cyc), 64'(e[EW-1 -: 16]));
      end
    end
    while (exp_q.size() > 0 && exp_q[0][EW-1 -: 16] < cyc) begin
      void'(exp_q.pop_front());
      chk("rv_lost", 1, 0);
    end
  end

  task automatic gen_port(input int p, input int preq, input int pwe,
                          input int raise, input int hold);
    if (!(rq[p] && !gnt_prev[p])) begin
      rq[p] = ($urandom_range(0, 99) < preq);
      wr[p] = ($urandom_range(0, 99) < pwe);
      ad[p] = ($urandom_range(0, 3) == 0) ?
              (32'hF000_0000 + 32'($urandom_range(0, 5)) * 4) :
              (32'($urandom_range(0, 15)) * 4);
      wd[p] = $urandom;
    end
    lk[p] = lk[p] ? ($urandom_range(0, 99) < hold) : ($urandom_range(0, 99) < raise);
  endtask

  task automatic drive(input logic rst);
    reset = rst;
    req0 = rq[0]; we0 = wr[0]; lock0 = lk[0]; addr0 = ad[0]; wdata0 = wd[0];
    req1 = rq[1]; we1 = wr[1]; lock1 = lk[1]; addr1 = ad[1]; wdata1 = wd[1];
  endtask

  // Checks this cycle's outputs against the rules, then advances the model.
  task automatic model_step(input logic rst);
    int win, nown;
    bit brk;
    arb_state_t exp_st;
    if (rst)             win = -1;
    else if (owner < 0)  win = (rq[0] && rq[1]) ? ((starve == SL) ? 1 : 0) :
                               rq[0] ? 0 : (rq[1] ? 1 : -1);
    else                 win = rq[owner] ? owner : -1;

    chk("gnt0", 64'(gnt0), 64'(win == 0));
    chk("gnt1", 64'(gnt1), 64'(win == 1));
    chk("mem_en", 64'(mem_en), 64'(win >= 0));
    chk("mem_we", 64'(mem_we), 64'((win >= 0) ? wr[win] : 1'b0));
    chk("mem_addr", 64'(mem_addr), 64'((win >= 0) ? ad[win] : '0));
    chk("mem_wdata", 64'(mem_wdata), 64'((win >= 0) ? wd[win] : '0));
    chk("err_lock", 64'(err_lock), 64'(err_pend && !rst));
    if (!rst) begin
      exp_st = (owner < 0) ? ST_IDLE : ((owner == 0) ? ST_OWN0 : ST_OWN1);
      chk("state", 64'(arb_state), 64'(exp_st));
      chk("starve_cnt", 64'(starve_cnt), 64'(starve));
      chk("lock_cnt", 64'(lock_cnt), 64'(lockc));
    end

    if (win >= 0) begin
      if (!wr[win]) exp_q.push_back({cyc + 16'd1, 1'(win), mmem[ad[win][5:2]]});
      else          mmem[ad[win][5:2]] = wd[win];
    end
    gnt_prev[0] = (win == 0);
    gnt_prev[1] = (win == 1);

    if (rst) begin
      owner = -1; starve = 0; lockc = 0; ign[0] = 0; ign[1] = 0; err_pend = 0;
    end else begin
      nown = owner;
      brk  = 0;
      starve = (win == 1 || !rq[1]) ? 0 : ((starve < SL) ? starve + 1 : SL);
      if (owner < 0) begin
        if (win >= 0 && lk[win] && !ign[win]) nown = win;
      end else if (!lk[owner]) begin
        nown = -1;
      end else if (lockc == LM - 1) begin
        nown = -1;
        brk  = 1;
        ign[owner] = 1;
      end
      lockc = (owner >= 0 && nown >= 0) ? lockc + 1 : 0;
      for (int p = 0; p < 2; p++) if (!lk[p]) ign[p] = 0;
      err_pend = brk;
      owner    = nown;
    end
  endtask

  // Bus-side memory: answers the DUT's actual bus accesses one cycle later.
  task automatic responder();
    resp_pend = mem_en && !mem_we;
    if (resp_pend) resp = bmem[mem_addr[5:2]];
    if (mem_en && mem_we) bmem[mem_addr[5:2]] = mem_wdata;
  endtask

  initial begin
    int preq0, preq1, pwe, raise, hold, prst;
    logic rst;
    for (int i = 0; i < 16; i++) begin
      bmem[i] = $urandom;
      mmem[i] = bmem[i];
    end
    for (int p = 0; p < 2; p++) begin
      rq[p] = 0; wr[p] = 0; lk[p] = 0; ad[p] = '0; wd[p] = '0; gnt_prev[p] = 0;
    end
    owner = -1; starve = 0; lockc = 0; ign[0] = 0; ign[1] = 0; err_pend = 0;
    resp_pend = 0; resp = '0; mem_rdata = '0;
    drive(1'b1);

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cyc = 16'(c);
      case ((c / 500) % 4)
        0:       begin preq0 = 40; preq1 = 40; pwe = 35; raise = 10; hold = 50; prst = 1; end
        1:       begin preq0 = 95; preq1 = 95; pwe = 30; raise = 3;  hold = 30; prst = 0; end
        2:       begin preq0 = 50; preq1 = 60; pwe = 35; raise = 30; hold = 97; prst = 1; end
        default: begin preq0 = 90; preq1 = 90; pwe = 0;  raise = 0;  hold = 0;  prst = 2; end
      endcase
      rst = (c < 3) || ($urandom_range(0, 99) < prst);
      if (rst) exp_q.delete();
      gen_port(0, preq0, pwe, raise, hold);
      gen_port(1, preq1, pwe, raise, hold);
      drive(rst);
      mem_rdata = resp_pend ? resp : $urandom;
      #2;
      model_step(rst);
      responder();
    end

    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      cyc = cyc + 16'd1;
      rq[0] = 0; rq[1] = 0; lk[0] = 0; lk[1] = 0;
      drive(1'b0);
      mem_rdata = resp_pend ? resp : $urandom;
      resp_pend = 0;
    end
    @(negedge clk);
    #1;
    chk("rv_drain", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
